dff_pipeline: RTL and testbench

Parametrised pipeline register: a chain of DEPTH rising-edge D flip-flop stages, each WIDTH bits wide, with per-stage valid tracking, a stall enable, a flush and an occupancy count. It is the next-generation replacement for the single-bit D flip-flop: configured as WIDTH=1, DEPTH=1 with en=1, it behaves as a plain D flip-flop with synchronous reset. It sits on any datapath needing fixed-latency delay or retiming with bubble tracking.

---
 rtl/dff_pipeline.sv | 87 ++++++++
 tb/tb_dff_pipeline.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dff_pipeline.sv
// DEPTH-stage registered delay line with per-stage valid, stall (en), flush and occupancy count.
// Define DFF_PIPE_EDGE_EN to add the rise/fall per-bit edge detectors on Q.
module dff_pipeline #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic [WIDTH-1:0] D,
   input  logic             d_valid,
   output logic [WIDTH-1:0] Q,
   output logic             q_valid,
`ifdef DFF_PIPE_EDGE_EN
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
`endif
   output logic [CW-1:0]    count
);

   if (DEPTH < 1) begin : g_bad_depth
      $error("dff_pipeline: DEPTH must be at least 1");
   end

   logic [DEPTH-1:0][WIDTH-1:0] s_q, s_d;
   logic [DEPTH-1:0]            v_q, v_d;
   logic [CW-1:0]               count_q, count_d;

   always_comb begin
      s_d = s_q;
      v_d = v_q;
      // flush wins over en: data holds, only the valid bits are cleared
      if (flush) begin
         v_d = '0;
      end else if (en) begin
         s_d[0] = D;
         v_d[0] = d_valid;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            s_d[i] = s_q[i-1];
            v_d[i] = v_q[i-1];
         end
      end
   end

   always_comb begin
      count_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         count_d = count_d + CW'(v_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s_q     <= {DEPTH{RESET_VALUE}};
         v_q     <= '0;
         count_q <= '0;
      end else begin
         s_q     <= s_d;
         v_q     <= v_d;
         count_q <= count_d;
      end
   end

   assign Q       = s_q[DEPTH-1];
   assign q_valid = v_q[DEPTH-1];
   assign count   = count_q;

`ifdef DFF_PIPE_EDGE_EN
   logic [WIDTH-1:0] qp_q;

   // qp tracks Q on every edge, so a stall (Q held) yields no pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         qp_q <= RESET_VALUE;
      end else begin
         qp_q <= s_q[DEPTH-1];
      end
   end

   assign rise = Q & ~qp_q;
   assign fall = ~Q & qp_q;
`endif

endmodule

// File: tb/tb_dff_pipeline.sv
// Self-checking bench for dff_pipeline: directed vector tables plus a queue scoreboard under random en/d_valid.
module tb_dff_pipeline;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // main pipe: WIDTH=8, DEPTH=4, RESET_VALUE=0x5A
   logic       p_rst = 1'b1, p_en = 1'b0, p_fl = 1'b0, p_dv = 1'b0;
   logic [7:0] p_d = '0, p_q;
   logic       p_qv;
   logic [2:0] p_cnt;

   dff_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h5A)) u_pipe (
      .clk(clk), .reset(p_rst), .en(p_en), .flush(p_fl), .D(p_d), .d_valid(p_dv),
      .Q(p_q), .q_valid(p_qv),
`ifdef DFF_PIPE_EDGE_EN
      .rise(), .fall(),
`endif
      .count(p_cnt));

   // plain flip-flop configuration
   logic f_rst = 1'b1, f_en = 1'b1, f_fl = 1'b0, f_dv = 1'b0, f_d = 1'b0;
   logic f_q, f_qv, f_cnt;

   dff_pipeline #(.WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b0)) u_dff (
      .clk(clk), .reset(f_rst), .en(f_en), .flush(f_fl), .D(f_d), .d_valid(f_dv),
      .Q(f_q), .q_valid(f_qv),
`ifdef DFF_PIPE_EDGE_EN
      .rise(), .fall(),
`endif
      .count(f_cnt));

`ifdef DFF_PIPE_EDGE_EN
   logic       e_rst = 1'b1, e_en = 1'b1;
   logic [1:0] e_d = '0, e_q, e_rise, e_fall;
   logic       e_qv, e_cnt;

   dff_pipeline #(.WIDTH(2), .DEPTH(1), .RESET_VALUE(2'b00)) u_edge (
      .clk(clk), .reset(e_rst), .en(e_en), .flush(1'b0), .D(e_d), .d_valid(1'b1),
      .Q(e_q), .q_valid(e_qv), .rise(e_rise), .fall(e_fall), .count(e_cnt));
`endif

   typedef struct {
      logic       rst, fl, en, dv;
      logic [7:0] d;
      logic [7:0] q;
      logic       qv;
      logic [2:0] cnt;
   } vec_t;

   typedef struct {
      logic [7:0]  d;
      int unsigned idx;
   } sb_t;

   vec_t pv[21];
   vec_t fv[6];
   sb_t  sbq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pipe_step(input logic rst, input logic fl, input logic en, input logic dv,
                            input logic [7:0] d);
      p_rst = rst; p_fl = fl; p_en = en; p_dv = dv; p_d = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned m;
      logic        exp_qv;
      logic [7:0]  exp_q;
      logic        q_known;
      logic        en_r, dv_r;
      logic [7:0]  d_r;
      sb_t         it;

      //        rst   fl    en    dv    D      Q      qv    cnt
      pv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 3'd0};
      pv[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 8'h5A, 1'b0, 3'd1};
      pv[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 8'h5A, 1'b0, 3'd2};
      pv[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 8'h5A, 1'b0, 3'd3};
      pv[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 8'h11, 1'b1, 3'd4};
      pv[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 8'h22, 1'b1, 3'd4};
      pv[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h66, 8'h22, 1'b1, 3'd4};
      pv[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 8'h33, 1'b1, 3'd3};
      pv[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h33, 1'b0, 3'd0};
      pv[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 8'h44, 1'b0, 3'd1};
      pv[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hB6, 8'h55, 1'b0, 3'd2};
      pv[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hC7, 8'h77, 1'b0, 3'd3};
      pv[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hD8, 8'h5A, 1'b0, 3'd0};
      pv[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 8'h5A, 1'b0, 3'd1};
      pv[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, 3'd1};
      pv[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hEE, 8'h5A, 1'b0, 3'd1};
      pv[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hEE, 8'h5A, 1'b0, 3'd1};
      pv[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hEE, 8'h5A, 1'b0, 3'd1};
      pv[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, 3'd1};
      pv[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b1, 3'd1};
      pv[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0};

      fv[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 8'h00, 1'b0, 3'd0};
      fv[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h01, 1'b1, 3'd1};
      fv[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 3'd1};
      fv[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 3'd1};
      fv[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h01, 1'b1, 3'd1};
      fv[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 3'd0};

      // directed table on the 4-deep pipe
      for (int i = 0; i < 21; i++) begin
         pipe_step(pv[i].rst, pv[i].fl, pv[i].en, pv[i].dv, pv[i].d);
         check($sformatf("pipe[%0d].Q", i),       32'(p_q),   32'(pv[i].q));
         check($sformatf("pipe[%0d].q_valid", i), 32'(p_qv),  32'(pv[i].qv));
         check($sformatf("pipe[%0d].count", i),   32'(p_cnt), 32'(pv[i].cnt));
      end

      // directed table on the plain flip-flop
      for (int i = 0; i < 6; i++) begin
         f_rst = fv[i].rst; f_fl = fv[i].fl; f_en = fv[i].en; f_dv = fv[i].dv; f_d = fv[i].d[0];
         @(posedge clk);
         #1;
         check($sformatf("dff[%0d].Q", i),       32'(f_q),   32'(fv[i].q[0]));
         check($sformatf("dff[%0d].q_valid", i), 32'(f_qv),  32'(fv[i].qv));
         check($sformatf("dff[%0d].count", i),   32'(f_cnt), 32'(fv[i].cnt[0]));
      end

`ifdef DFF_PIPE_EDGE_EN
      begin
         logic [1:0] ed[7], er[7], ef[7];
         logic       een[7];
         ed  = '{2'b11, 2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b01};
         een = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0};
         er  = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
         ef  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
         for (int i = 0; i < 7; i++) begin
            e_rst = (i == 0); e_en = een[i]; e_d = ed[i];
            @(posedge clk);
            #1;
            check($sformatf("edge[%0d].rise", i), 32'(e_rise), 32'(er[i]));
            check($sformatf("edge[%0d].fall", i), 32'(e_fall), 32'(ef[i]));
         end
      end
`endif

      // scoreboard phase: random stall/bubble pattern, items tagged with their capture edge index
      pipe_step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      check("sb.reset.count", 32'(p_cnt), 32'd0);
      m = 0; exp_qv = 1'b0; exp_q = 8'h5A; q_known = 1'b1;
      for (int c = 0; c < 300; c++) begin
         en_r = ($urandom_range(0, 3) != 0);
         dv_r = $urandom_range(0, 1) == 1;
         d_r  = 8'($urandom);
         if (en_r) begin
            m++;
            if (dv_r) sbq.push_back('{d_r, m});
         end
         pipe_step(1'b0, 1'b0, en_r, dv_r, d_r);
         if (en_r) begin
            if (sbq.size() > 0 && sbq[0].idx + 3 == m) begin
               it = sbq.pop_front();
               exp_qv = 1'b1; exp_q = it.d; q_known = 1'b1;
            end else begin
               exp_qv = 1'b0; q_known = 1'b0;
            end
         end
         check("sb.q_valid", 32'(p_qv), 32'(exp_qv));
         if (q_known) check("sb.Q", 32'(p_q), 32'(exp_q));
         check("sb.count", 32'(p_cnt), 32'(sbq.size()) + 32'(exp_qv));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
